sram_lsu_ctrl: RTL and testbench
================================

Name: sram_lsu_ctrl

Overview:
- Memory-side stage directly downstream of the instruction decoder/control unit in the single-cycle RV32I core.
- Accepts load/store requests (mem_read, mem_wren, num_byte, address, store data).
- Detects whether the address falls in the external SRAM window and runs multi-cycle 16-bit SRAM bus transfers.
- Returns extended load data plus a one-cycle o_ACK that releases the PC stall (en_pc).

Parameters:
- SRAM_BASE, 32'h8000_0000, byte base address of the SRAM window.
- SRAM_AW, 19, log2 of window size in bytes; SRAM word address width is SRAM_AW-1.
- WAIT_CYCLES, 2, cycles per 16-bit transfer with strobes asserted; legal range 1..15.

Ports:
- i_clk  in  1  core clock
- i_reset  in  1  reset, asynchronous active-high
- i_lsu_addr  in  32  byte address from the ALU
- i_st_data  in  32  store data (rs2)
- i_mem_read  in  1  load request, level, held until o_ACK
- i_mem_wren  in  1  store request, level, held until o_ACK
- i_num_byte  in  3  0 = lb, 1 = lbu, 2 = lh, 3 = lhu, 4 = lw/sw, 5-7 = treated as word
- o_in_sram  out  1  combinational: base <= addr < base + 2^SRAM_AW
- o_ACK  out  1  one-cycle pulse on access completion
- o_ld_data  out  32  extended load result, registered, held until next load completes
- o_misalign  out  1  combinational: half with addr[0] = 1, or word with addr[1:0] != 0
- SRAM_ADDR  out  SRAM_AW-1  halfword address
- SRAM_DQ  inout  16  data bus; driven only during write states, else high-Z
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N  out  1 each  active-low strobes

Behaviour:
- Reset (async, any state): state = IDLE, counter = 0, o_ACK = 0, o_ld_data = 0, all SRAM strobes = 1, SRAM_ADDR = 0, DQ released to high-Z.
- FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
- IDLE:
  - A request with o_in_sram = 1 is latched on the clock edge: address, data, size.
  - Store (wren) → WR_LO.
  - Load (read) → RD_LO.
  - Both wren and read asserted → store wins.
  - in_sram = 0 → stay in IDLE, no ACK.
- Address: offset = addr - SRAM_BASE, with low bits ignored per size (force-aligned).
  - Byte access: SRAM_ADDR = offset[SRAM_AW-1:1]; lane = offset[0] (0 → LB_N low, 1 → UB_N low).
  - Half access: SRAM_ADDR = offset[SRAM_AW-1:1] with bit 0 cleared; both lanes.
  - Word access: LO at {offset[SRAM_AW-1:2], 0}, HI at {offset[SRAM_AW-1:2], 1}; both lanes.
- RD_LO / RD_HI:
  - CE_N = 0, OE_N = 0, WE_N = 1 for WAIT_CYCLES cycles.
  - DQ is captured at the edge ending the last cycle.
  - Byte/half: RD_LO → DONE.
  - Word: RD_LO → RD_HI → DONE.
- WR_LO / WR_HI:
  - CE_N = 0, OE_N = 1; DQ driven for WAIT_CYCLES + 1 cycles.
  - WE_N = 0 for the first WAIT_CYCLES cycles, then 1 for a final hold cycle with address and data unchanged.
  - sb drives {st[7:0], st[7:0]} with only the selected lane enabled.
  - sh drives st[15:0]; sw drives st[15:0] then st[31:16].
- DONE:
  - o_ACK = 1 for exactly one cycle; all strobes high.
  - For loads, o_ld_data is updated on the edge entering DONE.
  - Next state is always IDLE, so back-to-back requests start no earlier than one cycle after the ACK cycle.
- Load extension: lb/lh sign-extend; lbu/lhu zero-extend; lw = {hi, lo}.
- Latency, counted from the first request cycle in IDLE as cycle 0:
  - ACK cycle = 1 + n·WAIT_CYCLES for loads, where n = 1 (byte/half) or 2 (word).
  - ACK cycle = 1 + n·(WAIT_CYCLES + 1) for stores.
- Request deasserted mid-transfer: the transfer completes and o_ACK still pulses.
- Misalignment: never blocks the access; o_misalign is informational only.
- Counter: 4-bit; resets to 0 on every state change.

Decomposition:
- Package sram_lsu_pkg holds:
  - state enum typedef;
  - num_byte encoding localparams (NB_LB = 0, NB_LBU = 1, NB_LH = 2, NB_LHU = 3, NB_W = 4);
  - strobe-idle constant.
- One combinational sub-module, sram_ld_ext: inputs size, lane, lo16, hi16; output is the 32-bit extended result.

Test Plan:
- Reset mid-RD_HI (word load): assert i_reset → same cycle: strobes all 1, DQ high-Z, o_ACK = 0; after release, FSM in IDLE.
- lw at 0x8000_0010, WAIT = 2, SRAM[8] = 0xBEEF, SRAM[9] = 0xDEAD:
  - SRAM_ADDR goes 8 then 9;
  - o_ACK at cycle 5;
  - o_ld_data = 0xDEADBEEF.
- lb at 0x8000_0003 with SRAM[1] = 0x80FF:
  - UB_N = 0, LB_N = 1;
  - o_ld_data = 0xFFFF_FF80;
  - lbu at the same address → 0x0000_0080.
- sh of 0x1234_5678 at 0x8000_0006, WAIT = 2:
  - SRAM_ADDR = 3, DQ = 0x5678;
  - WE_N low for 2 cycles then high for 1 cycle;
  - o_ACK at cycle 4;
  - sb at 0x8000_0001 → DQ = 0x7878, UB_N = 0, LB_N = 1.
- Address 0x0000_0100 with mem_read = 1: o_in_sram = 0, FSM stays IDLE, o_ACK never pulses, strobes stay high.
- Both read and wren asserted, and lw at 0x8000_0002:
  - Both asserted → a write cycle occurs.
  - lw at 0x8000_0002 → o_misalign = 1; access goes to halfwords 0 and 1.

Source files
------------

// File: rtl/sram_lsu_ctrl_pkg.sv
// sram_lsu_pkg: shared FSM type, access-size encodings and strobe constants for the SRAM LSU
package sram_lsu_pkg;

    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

    localparam logic [2:0] NB_LB  = 3'd0;
    localparam logic [2:0] NB_LBU = 3'd1;
    localparam logic [2:0] NB_LH  = 3'd2;
    localparam logic [2:0] NB_LHU = 3'd3;
    localparam logic [2:0] NB_W   = 3'd4;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic lb_n;
        logic ub_n;
    } strb_t;

    localparam strb_t STRB_IDLE = 5'b11111;

endpackage

// File: rtl/sram_lsu_ctrl_if.sv
// sram_lsu_ctrl_if: load/store request and response bundle between the core and the SRAM LSU
interface sram_lsu_ctrl_if;
    logic [31:0] i_lsu_addr;
    logic [31:0] i_st_data;
    logic        i_mem_read;
    logic        i_mem_wren;
    logic [2:0]  i_num_byte;
    logic        o_in_sram;
    logic        o_ACK;
    logic [31:0] o_ld_data;
    logic        o_misalign;

    modport master (
        output i_lsu_addr, i_st_data, i_mem_read, i_mem_wren, i_num_byte,
        input  o_in_sram, o_ACK, o_ld_data, o_misalign
    );

    modport slave (
        input  i_lsu_addr, i_st_data, i_mem_read, i_mem_wren, i_num_byte,
        output o_in_sram, o_ACK, o_ld_data, o_misalign
    );
endinterface

// File: rtl/sram_lsu_ctrl_ld_ext.sv
// sram_ld_ext: selects the loaded byte/halfword/word and sign- or zero-extends it to 32 bits
module sram_ld_ext
    import sram_lsu_pkg::*;
(
    input  logic [2:0]  i_size,
    input  logic        i_lane,
    input  logic [15:0] i_lo16,
    input  logic [15:0] i_hi16,
    output logic [31:0] o_data
);
    logic [7:0] w_byte;

    assign w_byte = i_lane ? i_lo16[15:8] : i_lo16[7:0];

    // Extend according to size; encodings above the word code read as a full word
    always_comb
        o_data = (i_size == NB_LB)  ? {{24{w_byte[7]}}, w_byte} :
                 (i_size == NB_LBU) ? {24'd0, w_byte} :
                 (i_size == NB_LH)  ? {{16{i_lo16[15]}}, i_lo16} :
                 (i_size == NB_LHU) ? {16'd0, i_lo16} : {i_hi16, i_lo16};
endmodule

// File: rtl/sram_lsu_ctrl.sv
// sram_lsu_ctrl: runs multi-cycle 16-bit SRAM transfers for core loads/stores in the SRAM window
module sram_lsu_ctrl
    import sram_lsu_pkg::*;
#(
    parameter logic [31:0] SRAM_BASE   = 32'h8000_0000,
    parameter int          SRAM_AW     = 19,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    sram_lsu_ctrl_if.slave     lsu,
    output logic [SRAM_AW-2:0] SRAM_ADDR,
    inout  wire  [15:0]        SRAM_DQ,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_WE_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_UB_N
);
    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);
    localparam logic [3:0] HOLD = 4'(WAIT_CYCLES);

    state_t             r_state;
    logic [3:0]         r_cnt;
    logic               r_ack;
    logic [31:0]        r_ld_data;
    strb_t              r_strb;
    logic [SRAM_AW-2:0] r_addr;
    logic [SRAM_AW-2:0] r_hi_addr;
    logic               r_dq_oe;
    logic [15:0]        r_dq;
    logic [15:0]        r_st_hi;
    logic [15:0]        r_lo16;
    logic [2:0]         r_nb;
    logic               r_lane;

    logic [31:0]        w_off;
    logic               w_in_sram;
    logic               w_word;
    logic               w_byte;
    logic               w_req;
    logic [SRAM_AW-2:0] w_lo_addr;
    logic [15:0]        w_wdata;
    logic [15:0]        w_lo16;
    logic [31:0]        w_ext;

    assign w_off     = lsu.i_lsu_addr - SRAM_BASE;
    assign w_in_sram = (lsu.i_lsu_addr >= SRAM_BASE) && (w_off < (32'd1 << SRAM_AW));
    assign w_word    = lsu.i_num_byte >= NB_W;
    assign w_byte    = lsu.i_num_byte < NB_LH;
    assign w_req     = (lsu.i_mem_wren || lsu.i_mem_read) && w_in_sram;
    assign w_lo_addr = w_word ? {w_off[SRAM_AW-1:2], 1'b0} : w_off[SRAM_AW-1:1];
    assign w_wdata   = w_byte ? {2{lsu.i_st_data[7:0]}} : lsu.i_st_data[15:0];
    // The low half comes straight off the bus when a single-transfer load finishes
    assign w_lo16    = (r_state == RD_LO) ? SRAM_DQ : r_lo16;

    sram_ld_ext u_ld_ext (
        .i_size (r_nb),
        .i_lane (r_lane),
        .i_lo16 (w_lo16),
        .i_hi16 (SRAM_DQ),
        .o_data (w_ext)
    );

    assign lsu.o_in_sram  = w_in_sram;
    assign lsu.o_misalign = (!w_word && !w_byte && lsu.i_lsu_addr[0]) || (w_word && |lsu.i_lsu_addr[1:0]);
    assign lsu.o_ACK      = r_ack;
    assign lsu.o_ld_data  = r_ld_data;
    assign SRAM_ADDR      = r_addr;
    assign {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N} = r_strb;
    assign SRAM_DQ        = r_dq_oe ? r_dq : 16'bz;

    // Transfer FSM; every bus pin and the ACK are registered so the SRAM sees glitch-free strobes
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_ack     <= 1'b0;
            r_ld_data <= '0;
            r_strb    <= STRB_IDLE;
            r_addr    <= '0;
            r_hi_addr <= '0;
            r_dq_oe   <= 1'b0;
            r_dq      <= '0;
            r_st_hi   <= '0;
            r_lo16    <= '0;
            r_nb      <= '0;
            r_lane    <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_cnt <= r_cnt + 4'd1;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_req) begin
                        r_state   <= lsu.i_mem_wren ? WR_LO : RD_LO;
                        r_nb      <= lsu.i_num_byte;
                        r_lane    <= w_off[0];
                        r_hi_addr <= {w_off[SRAM_AW-1:2], 1'b1};
                        r_st_hi   <= lsu.i_st_data[31:16];
                        r_addr    <= w_lo_addr;
                        r_dq      <= w_wdata;
                        r_dq_oe   <= lsu.i_mem_wren;
                        r_strb    <= '{ce_n: 1'b0, oe_n: lsu.i_mem_wren, we_n: !lsu.i_mem_wren,
                                       lb_n: w_byte && w_off[0], ub_n: w_byte && !w_off[0]};
                    end
                end
                RD_LO, RD_HI: begin
                    if (r_cnt == LAST) begin
                        r_cnt  <= '0;
                        r_lo16 <= w_lo16;
                        if (r_state == RD_LO && r_nb >= NB_W) begin
                            r_state <= RD_HI;
                            r_addr  <= r_hi_addr;
                        end else begin
                            r_state   <= DONE;
                            r_ld_data <= w_ext;
                            r_strb    <= STRB_IDLE;
                            r_ack     <= 1'b1;
                        end
                    end
                end
                WR_LO, WR_HI: begin
                    if (r_cnt == HOLD) begin
                        r_cnt <= '0;
                        if (r_state == WR_LO && r_nb >= NB_W) begin
                            r_state     <= WR_HI;
                            r_addr      <= r_hi_addr;
                            r_dq        <= r_st_hi;
                            r_strb.we_n <= 1'b0;
                        end else begin
                            r_state <= DONE;
                            r_strb  <= STRB_IDLE;
                            r_dq_oe <= 1'b0;
                            r_ack   <= 1'b1;
                        end
                    end else if (r_cnt == LAST) begin
                        r_strb.we_n <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sram_lsu_ctrl.sv
// tb_sram_lsu_ctrl: directed table plus random accesses against an SRAM model and a reference memory
module tb_sram_lsu_ctrl;
    localparam int          W    = 2;
    localparam logic [31:0] BASE = 32'h8000_0000;

    typedef struct {
        bit          wr;
        bit          rd;
        logic [2:0]  nb;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] ld;
        int          lat;
        bit          mis;
        bit          ins;
        int          a0;
        int          a1;
        logic [1:0]  lanes;
        logic [15:0] dq;
        int          we;
        int          drop;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        ce_n, oe_n, we_n, lb_n, ub_n;
    logic [15:0] mem     [256];
    logic [15:0] ref_mem [256];
    int          n_tests = 0;
    int          n_fail  = 0;
    vec_t        tbl [17];

    sram_lsu_ctrl_if lsu ();

    sram_lsu_ctrl #(.SRAM_BASE(BASE), .SRAM_AW(19), .WAIT_CYCLES(W)) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .lsu       (lsu),
        .SRAM_ADDR (sram_addr),
        .SRAM_DQ   (sram_dq),
        .SRAM_CE_N (ce_n),
        .SRAM_OE_N (oe_n),
        .SRAM_WE_N (we_n),
        .SRAM_LB_N (lb_n),
        .SRAM_UB_N (ub_n)
    );

    always #5 clk = ~clk;

    assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[7:0]] : 16'bz;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input bit wr, input bit rd, input logic [2:0] nb,
                                   input logic [31:0] addr, input logic [31:0] data);
        vec_t        v;
        int          off, n;
        logic [15:0] lo, hi;
        logic [7:0]  b;
        off     = int'(addr - BASE);
        n       = (nb >= 4) ? 2 : 1;
        v.wr    = wr;
        v.rd    = rd;
        v.nb    = nb;
        v.addr  = addr;
        v.data  = data;
        v.ins   = 1'b1;
        v.mis   = ((nb == 2 || nb == 3) && addr[0]) || (nb >= 4 && addr[1:0] != 2'b00);
        v.a0    = (nb >= 4) ? (off / 4) * 2 : off / 2;
        v.a1    = (nb >= 4) ? v.a0 + 1 : -1;
        v.lanes = (nb <= 1) ? ((off % 2 == 1) ? 2'b01 : 2'b10) : 2'b00;
        v.lat   = wr ? 1 + n * (W + 1) : 1 + n * W;
        v.we    = wr ? n * W : 0;
        v.dq    = (nb <= 1) ? {2{data[7:0]}} : data[15:0];
        v.drop  = 0;
        lo      = ref_mem[v.a0 % 256];
        hi      = ref_mem[(v.a0 + 1) % 256];
        b       = (off % 2 == 1) ? lo[15:8] : lo[7:0];
        case (nb)
            3'd0:    v.ld = 32'($signed(b));
            3'd1:    v.ld = 32'(b);
            3'd2:    v.ld = 32'($signed(lo));
            3'd3:    v.ld = 32'(lo);
            default: v.ld = {hi, lo};
        endcase
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] nb, input logic [31:0] addr, input logic [31:0] data);
        int off;
        off = int'(addr - BASE);
        if (nb >= 4) begin
            ref_mem[(off / 4) * 2]     = data[15:0];
            ref_mem[(off / 4) * 2 + 1] = data[31:16];
        end else if (nb >= 2) begin
            ref_mem[off / 2] = data[15:0];
        end else if (off % 2 == 1) begin
            ref_mem[off / 2][15:8] = data[7:0];
        end else begin
            ref_mem[off / 2][7:0] = data[7:0];
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int          cyc = 0, we_cnt = 0, na = 0, a0 = -1, a1 = -1;
        logic [1:0]  lanes = 2'b11;
        logic [15:0] dq = '0;
        bit          got = 1'b0;
        @(negedge clk);
        lsu.i_mem_wren = v.wr;
        lsu.i_mem_read = v.rd;
        lsu.i_num_byte = v.nb;
        lsu.i_lsu_addr = v.addr;
        lsu.i_st_data  = v.data;
        #1;
        chk({tag, " misalign"}, 32'(lsu.o_misalign), 32'(v.mis));
        chk({tag, " in_sram"}, 32'(lsu.o_in_sram), 32'(v.ins));
        while (cyc < ((v.lat == 0) ? 10 : 40) && !got) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (!ce_n) begin
                if (na == 0) begin
                    a0    = int'(sram_addr);
                    lanes = {ub_n, lb_n};
                    na    = 1;
                end else if (na == 1 && int'(sram_addr) != a0) begin
                    a1 = int'(sram_addr);
                    na = 2;
                end
                if (!we_n) begin
                    if (we_cnt == 0) dq = sram_dq;
                    we_cnt++;
                    if (!lb_n) mem[sram_addr[7:0]][7:0]  = sram_dq[7:0];
                    if (!ub_n) mem[sram_addr[7:0]][15:8] = sram_dq[15:8];
                end
            end
            if (lsu.o_ACK) got = 1'b1;
            if (v.drop != 0 && cyc == v.drop) begin
                lsu.i_mem_read = 1'b0;
                lsu.i_mem_wren = 1'b0;
            end
        end
        lsu.i_mem_read = 1'b0;
        lsu.i_mem_wren = 1'b0;
        if (v.lat == 0) begin
            chk({tag, " no_ack"}, 32'(got), 32'd0);
            chk({tag, " no_strobe"}, 32'(na), 32'd0);
        end else begin
            chk({tag, " ack_cycle"}, got ? 32'(cyc) : 32'hFFFF_FFFF, 32'(v.lat));
            chk({tag, " addr0"}, 32'(a0), 32'(v.a0));
            chk({tag, " addr1"}, 32'(a1), 32'(v.a1));
            chk({tag, " lanes"}, 32'(lanes), 32'(v.lanes));
            chk({tag, " we_cycles"}, 32'(we_cnt), 32'(v.we));
            if (v.wr) begin
                chk({tag, " dq"}, 32'(dq), 32'(v.dq));
                ref_store(v.nb, v.addr, v.data);
            end else begin
                chk({tag, " ld_data"}, lsu.o_ld_data, v.ld);
            end
            @(negedge clk);
            chk({tag, " ack_pulse"}, 32'(lsu.o_ACK), 32'd0);
        end
    endtask

    initial begin
        vec_t v;
        int   bad;
        rst = 1'b1;
        lsu.i_mem_read = 1'b0;
        lsu.i_mem_wren = 1'b0;
        lsu.i_num_byte = '0;
        lsu.i_lsu_addr = '0;
        lsu.i_st_data  = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[0] = 16'h1111; mem[1] = 16'h80FF; mem[8] = 16'hBEEF; mem[9] = 16'hDEAD;
        ref_mem[0] = 16'h1111; ref_mem[1] = 16'h80FF; ref_mem[8] = 16'hBEEF; ref_mem[9] = 16'hDEAD;

        tbl = '{
            '{0, 1, 3'd4, 32'h8000_0010, 32'h0,         32'hDEAD_BEEF, 5, 0, 1, 8,  9,  2'b00, 16'h0,    0, 0},
            '{0, 1, 3'd0, 32'h8000_0003, 32'h0,         32'hFFFF_FF80, 3, 0, 1, 1,  -1, 2'b01, 16'h0,    0, 0},
            '{0, 1, 3'd1, 32'h8000_0003, 32'h0,         32'h0000_0080, 3, 0, 1, 1,  -1, 2'b01, 16'h0,    0, 0},
            '{0, 1, 3'd4, 32'h8000_0002, 32'h0,         32'h80FF_1111, 5, 1, 1, 0,  1,  2'b00, 16'h0,    0, 0},
            '{1, 0, 3'd2, 32'h8000_0006, 32'h1234_5678, 32'h0,         4, 0, 1, 3,  -1, 2'b00, 16'h5678, 2, 0},
            '{0, 1, 3'd2, 32'h8000_0006, 32'h0,         32'h0000_5678, 3, 0, 1, 3,  -1, 2'b00, 16'h0,    0, 0},
            '{1, 0, 3'd0, 32'h8000_0001, 32'h1234_5678, 32'h0,         4, 0, 1, 0,  -1, 2'b01, 16'h7878, 2, 0},
            '{0, 1, 3'd2, 32'h8000_0000, 32'h0,         32'h0000_7811, 3, 0, 1, 0,  -1, 2'b00, 16'h0,    0, 0},
            '{1, 1, 3'd2, 32'h8000_0020, 32'h0000_CAFE, 32'h0,         4, 0, 1, 16, -1, 2'b00, 16'hCAFE, 2, 0},
            '{0, 1, 3'd3, 32'h8000_0020, 32'h0,         32'h0000_CAFE, 3, 0, 1, 16, -1, 2'b00, 16'h0,    0, 0},
            '{0, 1, 3'd2, 32'h8000_0020, 32'h0,         32'hFFFF_CAFE, 3, 0, 1, 16, -1, 2'b00, 16'h0,    0, 0},
            '{1, 0, 3'd4, 32'h8000_0044, 32'h1357_9BDF, 32'h0,         7, 0, 1, 34, 35, 2'b00, 16'h9BDF, 4, 0},
            '{0, 1, 3'd7, 32'h8000_0044, 32'h0,         32'h1357_9BDF, 5, 0, 1, 34, 35, 2'b00, 16'h0,    0, 2},
            '{0, 1, 3'd2, 32'h0000_0100, 32'h0,         32'h0,         0, 0, 0, 0,  -1, 2'b00, 16'h0,    0, 0},
            '{0, 1, 3'd4, 32'h8008_0000, 32'h0,         32'h0,         0, 0, 0, 0,  -1, 2'b00, 16'h0,    0, 0},
            '{0, 1, 3'd2, 32'h7FFF_FFFE, 32'h0,         32'h0,         0, 0, 0, 0,  -1, 2'b00, 16'h0,    0, 0},
            '{0, 0, 3'd2, 32'h8007_FFFF, 32'h0,         32'h0,         0, 1, 1, 0,  -1, 2'b00, 16'h0,    0, 0}
        };

        repeat (3) @(negedge clk);
        chk("reset ack", 32'(lsu.o_ACK), 32'd0);
        chk("reset ld_data", lsu.o_ld_data, 32'd0);
        chk("reset strobes", 32'({ce_n, oe_n, we_n, lb_n, ub_n}), 32'h1F);
        chk("reset addr", 32'(sram_addr), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        @(negedge clk);
        lsu.i_mem_read = 1'b1;
        lsu.i_num_byte = 3'd4;
        lsu.i_lsu_addr = 32'h8000_0010;
        repeat (W + 1) @(posedge clk);
        @(negedge clk);
        chk("midrd ce", 32'(ce_n), 32'd0);
        chk("midrd hi_addr", 32'(sram_addr), 32'd9);
        rst = 1'b1;
        #1;
        chk("midrd rst strobes", 32'({ce_n, oe_n, we_n, lb_n, ub_n}), 32'h1F);
        chk("midrd rst ack", 32'(lsu.o_ACK), 32'd0);
        chk("midrd rst ld_data", lsu.o_ld_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        lsu.i_mem_read = 1'b0;
        @(negedge clk);
        chk("post rst strobes", 32'({ce_n, oe_n, we_n, lb_n, ub_n}), 32'h1F);
        run_vec(tbl[0], "post_rst_lw");

        for (int i = 0; i < 40; i++) begin
            int op;
            op = int'($urandom_range(0, 2));
            v = model(op != 0, op != 1, 3'($urandom_range(0, 7)), BASE + 32'($urandom_range(0, 511)), $urandom);
            v.drop = int'($urandom_range(0, 3));
            run_vec(v, $sformatf("rand%0d", i));
        end

        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("final sram contents mismatching words", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
